// File: rtl/mips_multicycle_seq_if.sv
// Bundle of control and status signals between the multi-cycle sequencer and its datapath.
// master: the sequencer (drives strobes and status); slave: the datapath/memory side.
// Counter width follows CNT_W and must match the sequencer's CNT_W.
interface mips_multicycle_seq_if #(
  parameter int CNT_W = 32
);
  // Datapath -> sequencer
  logic             run;
  logic [5:0]       opfield;
  logic             alu_zero;
  logic             dm_ready;
  // Sequencer -> datapath
  logic             ir_we;
  logic             pc_we;
  logic             pc_branch;
  logic             reg_we;
  logic             dm_read;
  logic             dm_write;
  // Status
  logic [2:0]       state;
  logic             busy;
  logic             halted;
  logic             illegal_op;
  logic             mem_timeout;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  run, opfield, alu_zero, dm_ready,
    output ir_we, pc_we, pc_branch, reg_we, dm_read, dm_write,
    output state, busy, halted, illegal_op, mem_timeout,
    output instr_count, cycle_count
  );

  modport slave (
    output run, opfield, alu_zero, dm_ready,
    input  ir_we, pc_we, pc_branch, reg_we, dm_read, dm_write,
    input  state, busy, halted, illegal_op, mem_timeout,
    input  instr_count, cycle_count
  );
endinterface

// File: rtl/mips_multicycle_seq.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with single-cycle write strobes.
// Latency: beq 3, R/sw 4, lw 5, illegal 2 cycles; MEM stretches until dm_ready or timeout.
// Backpressure: MEM holds dm_read/dm_write until dm_ready; MCSEQ_PERF_EN enables perf counters.
module mips_multicycle_seq #(
  parameter int         MEM_WAIT_MAX = 15,
  parameter logic [5:0] HALT_OPCODE  = 6'h3F,
  parameter int         CNT_W        = 32
) (
  input logic                 clock,
  input logic                 PCreset,
  mips_multicycle_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

  state_t     state_q;
  logic [5:0] op_q;
  logic [7:0] wait_q;
  logic       illegal_q;
  logic       timeout_q;

  // Decode of the live opfield, only acted on while in DECODE
  logic op_legal;
  logic op_halt;
  assign op_legal = (bus.opfield == OP_R)  || (bus.opfield == OP_LW) ||
                    (bus.opfield == OP_SW) || (bus.opfield == OP_BEQ);
  assign op_halt  = !op_legal && (bus.opfield == HALT_OPCODE);

  // Ungated strobes; reset masks them below so nothing is written in a reset cycle
  logic ir_we_s, pc_we_s, pc_branch_s, reg_we_s, dm_read_s, dm_write_s;

  // Strobe decode from the state register plus the few inputs that steer a same-cycle commit
  always_comb begin
    ir_we_s     = 1'b0;
    pc_we_s     = 1'b0;
    pc_branch_s = 1'b0;
    reg_we_s    = 1'b0;
    dm_read_s   = 1'b0;
    dm_write_s  = 1'b0;
    case (state_q)
      S_FETCH:  ir_we_s = 1'b1;
      S_DECODE: pc_we_s = !op_legal && !op_halt;
      S_EXEC: begin
        if (op_q == OP_BEQ) begin
          pc_we_s     = 1'b1;
          pc_branch_s = bus.alu_zero;
        end
      end
      S_MEM: begin
        dm_read_s  = (op_q == OP_LW);
        dm_write_s = (op_q == OP_SW);
        pc_we_s    = (op_q == OP_SW) && bus.dm_ready;
      end
      S_WB: begin
        reg_we_s = 1'b1;
        pc_we_s  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ir_we     = ir_we_s     && !PCreset;
  assign bus.pc_we     = pc_we_s     && !PCreset;
  assign bus.pc_branch = pc_branch_s && !PCreset;
  assign bus.reg_we    = reg_we_s    && !PCreset;
  assign bus.dm_read   = dm_read_s   && !PCreset;
  assign bus.dm_write  = dm_write_s  && !PCreset;

  assign bus.state       = state_q;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted      = (state_q == S_HALT);
  assign bus.illegal_op  = illegal_q;
  assign bus.mem_timeout = timeout_q;

  // Sequencer FSM: state, latched opcode, MEM wait counter and sticky error flags
  always_ff @(posedge clock) begin
    if (PCreset) begin
      state_q   <= S_IDLE;
      op_q      <= 6'h00;
      wait_q    <= 8'h00;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.run) state_q <= S_FETCH;
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          // Opcode is captured here so later opfield changes cannot redirect the instruction
          op_q <= bus.opfield;
          if (op_legal) begin
            state_q <= S_EXEC;
          end else if (op_halt) begin
            state_q <= S_HALT;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
        S_EXEC: begin
          wait_q <= 8'h00;
          if (op_q == OP_BEQ)     state_q <= S_FETCH;
          else if (op_q == OP_R)  state_q <= S_WB;
          else                    state_q <= S_MEM;
        end
        S_MEM: begin
          // Ready on the limit cycle still completes the access
          if (bus.dm_ready) begin
            wait_q  <= 8'h00;
            state_q <= (op_q == OP_LW) ? S_WB : S_FETCH;
          end else if (wait_q == WAIT_LIMIT) begin
            timeout_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            wait_q <= wait_q + 8'h01;
          end
        end
        S_WB:    state_q <= S_FETCH;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MCSEQ_PERF_EN
  logic [CNT_W-1:0] instr_q;
  logic [CNT_W-1:0] cycle_q;

  // Retired-instruction and busy-cycle counters, wrapping at 2^CNT_W
  always_ff @(posedge clock) begin
    if (PCreset) begin
      instr_q <= '0;
      cycle_q <= '0;
    end else begin
      if (bus.pc_we) instr_q <= instr_q + CNT_W'(1);
      if (bus.busy)  cycle_q <= cycle_q + CNT_W'(1);
    end
  end

  assign bus.instr_count = instr_q;
  assign bus.cycle_count = cycle_q;
`else
  assign bus.instr_count = '0;
  assign bus.cycle_count = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_seq.sv
// Directed bench for mips_multicycle_seq: each step drives inputs and queues the expected outputs,
// a negedge checker pops and compares them. Counter expectations follow MCSEQ_PERF_EN.
module tb_mips_multicycle_seq;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3;
  localparam logic [2:0] ST_MEM  = 3'd4, ST_WB    = 3'd5, ST_HALT   = 3'd6;

  logic clock = 1'b0;
  logic PCreset;
  always #5 clock = ~clock;

  mips_multicycle_seq_if #(.CNT_W(32)) bus ();

  mips_multicycle_seq #(
    .MEM_WAIT_MAX(15),
    .HALT_OPCODE (6'h3F),
    .CNT_W       (32)
  ) dut (
    .clock  (clock),
    .PCreset(PCreset),
    .bus    (bus)
  );

  typedef struct {
    string       tag;
    logic [14:0] v;
    logic [31:0] ic;
    logic [31:0] cc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [14:0] obs;
  int          ncmp = 0;
  int          nfail = 0;
  logic [31:0] m_ic = 0;
  logic [31:0] m_cc = 0;
  logic        m_ill = 1'b0;
  logic        m_to = 1'b0;

  // Drive one cycle of inputs and queue what the outputs must be during that cycle
  task automatic step(input string tag, input logic rst, input logic rn, input logic [5:0] op,
                      input logic az, input logic dr, input logic [2:0] st,
                      input logic ir, input logic pc, input logic br, input logic rg,
                      input logic rd, input logic wr);
    exp_t x;
    logic bsy;
    @(posedge clock);
    #1;
    PCreset      = rst;
    bus.run      = rn;
    bus.opfield  = op;
    bus.alu_zero = az;
    bus.dm_ready = dr;
    bsy = (st != ST_IDLE) && (st != ST_HALT);
    x.tag = tag;
    x.v   = {st, ir, pc, br, rg, rd, wr, bsy, (st == ST_HALT), m_ill, m_to};
`ifdef MCSEQ_PERF_EN
    x.ic = m_ic;
    x.cc = m_cc;
`else
    x.ic = 32'd0;
    x.cc = 32'd0;
`endif
    sb.push_back(x);
    if (rst) begin
      m_ic  = 0;
      m_cc  = 0;
      m_ill = 1'b0;
      m_to  = 1'b0;
    end else begin
      if (pc)  m_ic = m_ic + 1;
      if (bsy) m_cc = m_cc + 1;
    end
  endtask

  // Scoreboard checker, sampling mid-cycle
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      obs = {bus.state, bus.ir_we, bus.pc_we, bus.pc_branch, bus.reg_we, bus.dm_read,
             bus.dm_write, bus.busy, bus.halted, bus.illegal_op, bus.mem_timeout};
      ncmp++;
      assert (obs === e.v) else begin
        nfail++;
        $error("FAIL %s outputs: observed %b expected %b", e.tag, obs, e.v);
      end
      ncmp++;
      assert ({bus.instr_count, bus.cycle_count} === {e.ic, e.cc}) else begin
        nfail++;
        $error("FAIL %s counters: observed ic=%0d cc=%0d expected ic=%0d cc=%0d",
               e.tag, bus.instr_count, bus.cycle_count, e.ic, e.cc);
      end
    end
  end

  initial begin
    PCreset      = 1'b1;
    bus.run      = 1'b0;
    bus.opfield  = 6'h00;
    bus.alu_zero = 1'b0;
    bus.dm_ready = 1'b0;
    repeat (2) @(posedge clock);

    //   tag            rst run op     az dr state      ir pc br rg rd wr
    step("reset",        1, 0, 6'h00, 0, 0, ST_IDLE,   0, 0, 0, 0, 0, 0);
    // R-type, opfield changed after DECODE must be ignored
    step("t1_idle",      0, 1, 6'h00, 0, 0, ST_IDLE,   0, 0, 0, 0, 0, 0);
    step("t1_fetch",     0, 0, 6'h00, 0, 0, ST_FETCH,  1, 0, 0, 0, 0, 0);
    step("t1_decode",    0, 0, 6'h00, 0, 0, ST_DECODE, 0, 0, 0, 0, 0, 0);
    step("t1_exec",      0, 0, 6'h3A, 0, 0, ST_EXEC,   0, 0, 0, 0, 0, 0);
    step("t1_wb",        0, 0, 6'h3A, 0, 0, ST_WB,     0, 1, 0, 1, 0, 0);
    // lw with three wait cycles
    step("t2_fetch",     0, 0, 6'h23, 0, 0, ST_FETCH,  1, 0, 0, 0, 0, 0);
    step("t2_decode",    0, 0, 6'h23, 0, 0, ST_DECODE, 0, 0, 0, 0, 0, 0);
    step("t2_exec",      0, 0, 6'h23, 0, 0, ST_EXEC,   0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("t2_mem_wait",0, 0, 6'h23, 0, 0, ST_MEM,    0, 0, 0, 0, 1, 0);
    step("t2_mem_done",  0, 0, 6'h23, 0, 1, ST_MEM,    0, 0, 0, 0, 1, 0);
    step("t2_wb",        0, 0, 6'h23, 0, 0, ST_WB,     0, 1, 0, 1, 0, 0);
    // beq taken then not taken
    step("t3_fetch",     0, 0, 6'h04, 0, 0, ST_FETCH,  1, 0, 0, 0, 0, 0);
    step("t3_decode",    0, 0, 6'h04, 0, 0, ST_DECODE, 0, 0, 0, 0, 0, 0);
    step("t3_taken",     0, 0, 6'h04, 1, 0, ST_EXEC,   0, 1, 1, 0, 0, 0);
    step("t3_fetch2",    0, 0, 6'h04, 1, 0, ST_FETCH,  1, 0, 0, 0, 0, 0);
    step("t3_decode2",   0, 0, 6'h04, 1, 0, ST_DECODE, 0, 0, 0, 0, 0, 0);
    step("t3_not_taken", 0, 0, 6'h04, 0, 0, ST_EXEC,   0, 1, 0, 0, 0, 0);
    // sw completing on first MEM cycle
    step("sw_fetch",     0, 0, 6'h2B, 0, 0, ST_FETCH,  1, 0, 0, 0, 0, 0);
    step("sw_decode",    0, 0, 6'h2B, 0, 0, ST_DECODE, 0, 0, 0, 0, 0, 0);
    step("sw_exec",      0, 0, 6'h2B, 0, 0, ST_EXEC,   0, 0, 0, 0, 0, 0);
    step("sw_mem_done",  0, 0, 6'h2B, 0, 1, ST_MEM,    0, 1, 0, 0, 0, 1);
    // illegal opcode skipped with a pc_we pulse
    step("ill_fetch",    0, 0, 6'h3A, 0, 0, ST_FETCH,  1, 0, 0, 0, 0, 0);
    step("ill_decode",   0, 0, 6'h3A, 0, 0, ST_DECODE, 0, 1, 0, 0, 0, 0);
    m_ill = 1'b1;
    step("ill_fetch2",   0, 0, 6'h2B, 0, 0, ST_FETCH,  1, 0, 0, 0, 0, 0);
    // reset in the middle of an sw MEM wait, ready arriving in the reset cycle
    step("t5_decode",    0, 0, 6'h2B, 0, 0, ST_DECODE, 0, 0, 0, 0, 0, 0);
    step("t5_exec",      0, 0, 6'h2B, 0, 0, ST_EXEC,   0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      step("t5_mem_wait",0, 0, 6'h2B, 0, 0, ST_MEM,    0, 0, 0, 0, 0, 1);
    step("t5_rst_mem",   1, 0, 6'h2B, 0, 1, ST_MEM,    0, 0, 0, 0, 0, 0);
    step("t5_idle",      0, 0, 6'h2B, 0, 0, ST_IDLE,   0, 0, 0, 0, 0, 0);
    // sw with ready on the limit cycle succeeds
    step("lim_idle",     0, 1, 6'h2B, 0, 0, ST_IDLE,   0, 0, 0, 0, 0, 0);
    step("lim_fetch",    0, 0, 6'h2B, 0, 0, ST_FETCH,  1, 0, 0, 0, 0, 0);
    step("lim_decode",   0, 0, 6'h2B, 0, 0, ST_DECODE, 0, 0, 0, 0, 0, 0);
    step("lim_exec",     0, 0, 6'h2B, 0, 0, ST_EXEC,   0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++)
      step("lim_wait",   0, 0, 6'h2B, 0, 0, ST_MEM,    0, 0, 0, 0, 0, 1);
    step("lim_ready",    0, 0, 6'h2B, 0, 1, ST_MEM,    0, 1, 0, 0, 0, 1);
    // sw timing out: no pc_we, HALT with mem_timeout, run ignored
    step("to_fetch",     0, 0, 6'h2B, 0, 0, ST_FETCH,  1, 0, 0, 0, 0, 0);
    step("to_decode",    0, 0, 6'h2B, 0, 0, ST_DECODE, 0, 0, 0, 0, 0, 0);
    step("to_exec",      0, 0, 6'h2B, 0, 0, ST_EXEC,   0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      step("to_wait",    0, 0, 6'h2B, 0, 0, ST_MEM,    0, 0, 0, 0, 0, 1);
    m_to = 1'b1;
    step("to_halt",      0, 1, 6'h2B, 0, 1, ST_HALT,   0, 0, 0, 0, 0, 0);
    step("to_halt2",     0, 1, 6'h2B, 0, 1, ST_HALT,   0, 0, 0, 0, 0, 0);
    // reset out of HALT, then halt opcode
    step("t6_rst",       1, 1, 6'h00, 0, 0, ST_HALT,   0, 0, 0, 0, 0, 0);
    step("t6_idle",      0, 1, 6'h00, 0, 0, ST_IDLE,   0, 0, 0, 0, 0, 0);
    step("t6_fetch",     0, 0, 6'h3F, 0, 0, ST_FETCH,  1, 0, 0, 0, 0, 0);
    step("t6_decode",    0, 0, 6'h3F, 0, 0, ST_DECODE, 0, 0, 0, 0, 0, 0);
    step("t6_halt",      0, 1, 6'h00, 0, 0, ST_HALT,   0, 0, 0, 0, 0, 0);
    step("t6_halt_hold", 0, 1, 6'h23, 0, 1, ST_HALT,   0, 0, 0, 0, 0, 0);

    @(negedge clock);
    #1;
    ncmp++;
    assert (sb.size() == 0) else begin
      nfail++;
      $error("FAIL drain: observed %0d queued expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
